// File: rtl/shield_hit_detector.sv
// shield_hit_detector
// Pixel-level collision detector in front of the shield bitmap. Produces
// same-cycle erase strobes (rate-limited per frame for missiles) and latches
// per-frame collision events that are reported as one-cycle pulses right
// after each startOfFrame, plus a saturating count of blocked-shot frames.
//
// There is no FSM and no handshake: the pixel stream is free-running, so the
// erase strobes are valid on every cycle and the event pulses are valid only
// on the cycle after startOfFrame.
module shield_hit_detector #(
    parameter int MAX_ERASE_PER_FRAME = 16,
    parameter int CNT_W               = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        playGame,
    input  logic        shieldDR,
    input  logic        playerMissileDR,
    input  logic        alienMissileDR,
    input  logic        alienDR,
    output logic        collisionShield,
    output logic        collisionShield_alien,
    output logic        playerShotBlocked,
    output logic        alienShotBlocked,
    output logic        aliensReachedShield,
    output logic [15:0] blockedCount
);

    localparam logic [CNT_W-1:0] maxErase = CNT_W'(MAX_ERASE_PER_FRAME);

    logic             pHit;
    logic             aHit;
    logic             bHit;
    logic             alienMissileErase;
    logic [CNT_W-1:0] pCnt;
    logic [CNT_W-1:0] aCnt;
    logic             pFlag;
    logic             aFlag;
    logic             bFlag;
    logic             pEvent;
    logic             aEvent;
    logic             bEvent;

    // Raw coincidences, erase strobes and the frame-event view that folds in a
    // hit landing on the startOfFrame cycle itself.
    always_comb begin
        pHit                  = shieldDR & playerMissileDR & playGame;
        aHit                  = shieldDR & alienMissileDR & playGame;
        bHit                  = shieldDR & alienDR & playGame;
        // Compare against the pre-increment count: the strobe at MAX-1 is the
        // last one let through in a frame.
        collisionShield       = pHit & (pCnt < maxErase);
        alienMissileErase     = aHit & (aCnt < maxErase);
        // Alien bodies are never limited, they wipe the shield completely.
        collisionShield_alien = bHit | alienMissileErase;
        pEvent                = playGame & (pFlag | pHit);
        aEvent                = playGame & (aFlag | aHit);
        bEvent                = playGame & (bFlag | bHit);
    end

    // Per-source erase counters; they stop at MAX because no strobe is issued
    // once the limit is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            pCnt <= '0;
            aCnt <= '0;
        end else if (startOfFrame) begin
            pCnt <= '0;
            aCnt <= '0;
        end else begin
            if (collisionShield) begin
                pCnt <= pCnt + CNT_W'(1);
            end
            if (alienMissileErase) begin
                aCnt <= aCnt + CNT_W'(1);
            end
        end
    end

    // Sticky per-frame event flags, independent of the erase limit; held
    // clear while no game is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            pFlag <= 1'b0;
            aFlag <= 1'b0;
            bFlag <= 1'b0;
        end else if (startOfFrame || !playGame) begin
            pFlag <= 1'b0;
            aFlag <= 1'b0;
            bFlag <= 1'b0;
        end else begin
            pFlag <= pFlag | pHit;
            aFlag <= aFlag | aHit;
            bFlag <= bFlag | bHit;
        end
    end

    // One-cycle event pulses on the cycle after startOfFrame.
    always_ff @(posedge clk) begin
        if (reset) begin
            playerShotBlocked   <= 1'b0;
            alienShotBlocked    <= 1'b0;
            aliensReachedShield <= 1'b0;
        end else begin
            playerShotBlocked   <= startOfFrame & pEvent;
            alienShotBlocked    <= startOfFrame & aEvent;
            aliensReachedShield <= startOfFrame & bEvent;
        end
    end

    // Saturating count of frames in which any shot was blocked.
    always_ff @(posedge clk) begin
        if (reset) begin
            blockedCount <= '0;
        end else if (startOfFrame && (pEvent || aEvent) && (blockedCount != 16'hFFFF)) begin
            blockedCount <= blockedCount + 16'd1;
        end
    end

endmodule
